qgemm_sram_cell_arbiter: RTL and testbench
==========================================

Name: qgemm_sram_cell_arbiter

Overview:
- Round-robin arbiter that shares one single-port SRAM cell (1R1W cell used with a single index, byte write-enable, synchronous read) among NUM_REQ requesters.
- Typical requesters: the AXI SRAM controller's cell port and the QGEMM engine's operand/result ports.
- Sits between requester cell-style ports and the memory cell.
- Issues at most one access per cycle and returns read data one cycle later, tagged to the requester that issued the read.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- BW_DATA, 32, cell data width.
- BW_INDEX, 14, cell index width.
- BW_BYTE_WEN, BW_DATA/8, byte write-enable width.
- MAX_LOCK, 16, maximum consecutive locked grants (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- rq_req_list  in  NUM_REQ  access request per requester
- rq_wenable_list  in  NUM_REQ  1=write, 0=read
- rq_index_list  in  BW_INDEX*NUM_REQ  cell index, packed (requester i at [BW_INDEX*(i+1)-1 -:BW_INDEX])
- rq_wbyte_list  in  BW_BYTE_WEN*NUM_REQ  byte write-enables, packed
- rq_wdata_list  in  BW_DATA*NUM_REQ  write data, packed
- rq_lock_list  in  NUM_REQ  hold grant (optional feature only; ignored otherwise)
- rq_grant_list  out  NUM_REQ  one-hot grant, combinational, same cycle as the request
- rq_rvalid_list  out  NUM_REQ  read data valid, one-hot, registered
- rq_rdata  out  BW_DATA  read data, broadcast to all requesters
- cell_index  out  BW_INDEX  to cell
- cell_enable  out  1  to cell
- cell_wenable  out  1  to cell
- cell_wenable_byte  out  BW_BYTE_WEN  to cell
- cell_wdata  out  BW_DATA  to cell
- cell_renable  out  1  to cell
- cell_rdata  in  BW_DATA  from cell, valid the cycle after cell_renable

Behaviour:
- Reset (rst high, asynchronous):
  - rr_ptr=0, rvalid_q=0, rtag_q=0, lock_cnt=0.
  - While rst is high, rq_grant_list=0 and all cell_* enables=0.
- Arbitration (combinational):
  - Search rq_req_list starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first asserted requester g gets rq_grant_list[g]=1.
  - No request: grant=0, cell_enable=0, cell_wenable=0, cell_renable=0.
  - Requester handshake: an access completes in any cycle where req&grant. The requester holds req and its fields stable until granted.
- Cell drive when granted:
  - cell_enable=1.
  - cell_index, cell_wdata, cell_wenable_byte are muxed from requester g.
  - cell_wenable = rq_wenable_list[g].
  - cell_renable = ~rq_wenable_list[g].
  - Write with all-zero wbyte: still granted and issued; the cell writes nothing.
- Pointer update (posedge):
  - On a grant, rr_ptr <= (g==NUM_REQ-1) ? 0 : g+1.
  - Otherwise rr_ptr is held.
- Read return:
  - On a granted read, rvalid_q<=1 and rtag_q<=g; otherwise rvalid_q<=0.
  - rq_rvalid_list = rvalid_q ? onehot(rtag_q) : 0.
  - rq_rdata = cell_rdata, unregistered; the cell's synchronous output is used directly.
  - Latency is exactly 1 cycle. There is no backpressure, so the requester must accept the data in that cycle.
- Back-to-back:
  - A new access may be granted in the same cycle the previous read returns.
  - Write-then-read of the same index on consecutive cycles returns the new data (the cell writes on the first edge).
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 grants.
- rst asserted mid-read: the pending rvalid is dropped and not replayed.

Optional Feature:
- Macro: QGEMM_SRAM_ARB_BURST_LOCK_EN.
- Enabled:
  - If the granted requester g has rq_lock_list[g]=1, rr_ptr is not advanced and lock_cnt increments.
  - g keeps priority while it requests with lock=1 and lock_cnt<MAX_LOCK-1.
  - At the MAX_LOCK-th consecutive locked grant, rr_ptr advances to g+1 and lock_cnt resets.
  - lock_cnt also resets on any unlocked grant, or on an idle cycle where g does not request.
- Disabled: rq_lock_list is unused and lock_cnt does not exist.

Decomposition:
- Shared package:
  - Read-latency constant (1).
  - Packed-slice helper macros for the *_list ports.
  - Default BW_INDEX/BW_DATA constants shared with the SRAM wrapper.
- Sub-module: qgemm_rr_pick, a combinational round-robin one-hot picker (req, ptr -> grant, index). It is reusable by other QGEMM arbiters.

Test Plan:
- Reset: assert rst mid-read with rvalid pending -> rq_rvalid_list=0 and grant=0 immediately; after release, rr_ptr=0.
- Single requester: req0 writes index 5, data 0xDEADBEEF, wbyte 4'hF; next cycle req0 reads index 5 -> one cycle later rq_rvalid_list=2'b01, rq_rdata=0xDEADBEEF.
- Contention, NUM_REQ=2, both reading every cycle: grants alternate 01,10,01,10; each rvalid matches the requester granted one cycle earlier.
- Byte enable: write 0x11223344 to index 9, then write 0xAABBCCDD with wbyte 4'b0101 -> read returns 0x11BB33DD.
- Wrap and skip, NUM_REQ=4: requests only from 3 and 1 -> grant order 1,3,1,3; rr_ptr wraps 3->0 correctly.
- Lock (macro on, MAX_LOCK=4): req0 with lock=1 and req1 both requesting -> four grants to 0, then grant to 1.
- Lock (macro off), same stimulus -> strict alternation.

Source files
------------

// File: rtl/qgemm_sram_cell_arbiter_pkg.sv
// Shared constants and packed-list slice helpers for the QGEMM SRAM cell arbiter.
// Optional burst lock is enabled with the QGEMM_SRAM_ARB_BURST_LOCK_EN macro.
`ifndef QGEMM_SLICE
`define QGEMM_SLICE(vec, i, w) vec[(w)*((i)+1)-1 -: (w)]
`endif

package qgemm_sram_cell_arbiter_pkg;

  localparam int QGEMM_READ_LATENCY = 1;
  localparam int QGEMM_BW_DATA      = 32;
  localparam int QGEMM_BW_INDEX     = 14;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/qgemm_sram_cell_arbiter_rr_pick.sv
// qgemm_rr_pick: combinational round-robin one-hot picker, search starts at ptr
// and wraps modulo N. Reusable by any QGEMM arbiter.
module qgemm_rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int off = 0; off < N; off++) begin
      int k;
      k = (int'(ptr) + off) % N;
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = PW'(k);
      end
    end
  end

endmodule

// File: rtl/qgemm_sram_cell_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM cell among NUM_REQ requesters.
// Build option: QGEMM_SRAM_ARB_BURST_LOCK_EN lets a requester hold priority for up to MAX_LOCK grants.
module qgemm_sram_cell_arbiter
  import qgemm_sram_cell_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int BW_DATA     = QGEMM_BW_DATA,
  parameter int BW_INDEX    = QGEMM_BW_INDEX,
  parameter int BW_BYTE_WEN = BW_DATA / 8,
  parameter int MAX_LOCK    = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              rq_req_list,
  input  logic [NUM_REQ-1:0]              rq_wenable_list,
  input  logic [BW_INDEX*NUM_REQ-1:0]     rq_index_list,
  input  logic [BW_BYTE_WEN*NUM_REQ-1:0]  rq_wbyte_list,
  input  logic [BW_DATA*NUM_REQ-1:0]      rq_wdata_list,
  input  logic [NUM_REQ-1:0]              rq_lock_list,
  output logic [NUM_REQ-1:0]              rq_grant_list,
  output logic [NUM_REQ-1:0]              rq_rvalid_list,
  output logic [BW_DATA-1:0]              rq_rdata,
  output logic [BW_INDEX-1:0]             cell_index,
  output logic                            cell_enable,
  output logic                            cell_wenable,
  output logic [BW_BYTE_WEN-1:0]          cell_wenable_byte,
  output logic [BW_DATA-1:0]              cell_wdata,
  output logic                            cell_renable,
  input  logic [BW_DATA-1:0]              cell_rdata
);

  localparam int PW = ptr_width(NUM_REQ);

  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      g_idx;
  logic [PW-1:0]      next_ptr;
  logic [NUM_REQ-1:0] pick_grant;
  logic               pick_any;
  logic               granted;
  logic               rvalid_q;
  logic [PW-1:0]      rtag_q;

  logic [BW_INDEX-1:0]    idx_arr   [NUM_REQ];
  logic [BW_BYTE_WEN-1:0] wbyte_arr [NUM_REQ];
  logic [BW_DATA-1:0]     wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign idx_arr[i]   = `QGEMM_SLICE(rq_index_list, i, BW_INDEX);
    assign wbyte_arr[i] = `QGEMM_SLICE(rq_wbyte_list, i, BW_BYTE_WEN);
    assign wdata_arr[i] = `QGEMM_SLICE(rq_wdata_list, i, BW_DATA);
  end

  qgemm_rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req   (rq_req_list),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (g_idx),
    .any   (pick_any)
  );

  // Reset masks the grant combinationally so nothing reaches the cell while rst is high.
  assign granted       = pick_any & ~rst;
  assign rq_grant_list = rst ? '0 : pick_grant;
  assign next_ptr      = (g_idx == PW'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;

  always_comb begin
    cell_enable       = granted;
    cell_wenable      = granted & rq_wenable_list[g_idx];
    cell_renable      = granted & ~rq_wenable_list[g_idx];
    cell_index        = idx_arr[g_idx];
    cell_wenable_byte = wbyte_arr[g_idx];
    cell_wdata        = wdata_arr[g_idx];
  end

`ifdef QGEMM_SRAM_ARB_BURST_LOCK_EN
  localparam int LW = $clog2(MAX_LOCK) + 1;

  logic [LW-1:0] lock_cnt;
  logic [LW-1:0] run_cnt;

  // A locked grant to someone other than the pointer owner starts a fresh run.
  assign run_cnt = (g_idx == rr_ptr) ? lock_cnt : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      rvalid_q <= 1'b0;
      rtag_q   <= '0;
      lock_cnt <= '0;
    end else begin
      rvalid_q <= granted & ~rq_wenable_list[g_idx];
      if (granted && !rq_wenable_list[g_idx]) rtag_q <= g_idx;
      if (granted && rq_lock_list[g_idx]) begin
        if (run_cnt >= LW'(MAX_LOCK - 1)) begin
          rr_ptr   <= next_ptr;
          lock_cnt <= '0;
        end else begin
          rr_ptr   <= g_idx;
          lock_cnt <= run_cnt + 1'b1;
        end
      end else begin
        if (granted) rr_ptr <= next_ptr;
        lock_cnt <= '0;
      end
    end
  end
`else
  logic unused_lock;
  localparam int UNUSED_MAX_LOCK = MAX_LOCK;
  assign unused_lock = ^rq_lock_list;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      rvalid_q <= 1'b0;
      rtag_q   <= '0;
    end else begin
      rvalid_q <= granted & ~rq_wenable_list[g_idx];
      if (granted && !rq_wenable_list[g_idx]) rtag_q <= g_idx;
      if (granted) rr_ptr <= next_ptr;
    end
  end
`endif

  always_comb begin
    rq_rvalid_list = '0;
    if (rvalid_q) rq_rvalid_list[rtag_q] = 1'b1;
  end

  assign rq_rdata = cell_rdata;

endmodule

// File: tb/tb_qgemm_sram_cell_arbiter.sv
// Directed self-checking bench for qgemm_sram_cell_arbiter (2- and 4-requester instances).
// Lock expectations follow QGEMM_SRAM_ARB_BURST_LOCK_EN.
module tb_qgemm_sram_cell_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Two-requester instance with a behavioural SRAM cell
  logic [1:0]  req, wen, lock, grant, rvalid;
  logic [27:0] idx;
  logic [7:0]  wbyte;
  logic [63:0] wdata;
  logic [31:0] rdata, cell_wdata, cell_rdata;
  logic [13:0] cell_index;
  logic [3:0]  cell_wbyte;
  logic        cell_enable, cell_wenable, cell_renable;

  qgemm_sram_cell_arbiter #(.NUM_REQ(2), .MAX_LOCK(4)) dut (
    .clk(clk), .rst(rst),
    .rq_req_list(req), .rq_wenable_list(wen), .rq_index_list(idx),
    .rq_wbyte_list(wbyte), .rq_wdata_list(wdata), .rq_lock_list(lock),
    .rq_grant_list(grant), .rq_rvalid_list(rvalid), .rq_rdata(rdata),
    .cell_index(cell_index), .cell_enable(cell_enable), .cell_wenable(cell_wenable),
    .cell_wenable_byte(cell_wbyte), .cell_wdata(cell_wdata),
    .cell_renable(cell_renable), .cell_rdata(cell_rdata)
  );

  logic [31:0] mem [64];
  initial for (int i = 0; i < 64; i++) mem[i] = 32'h0;

  always @(posedge clk) begin
    if (cell_enable && cell_wenable)
      for (int b = 0; b < 4; b++)
        if (cell_wbyte[b]) mem[cell_index[5:0]][8*b +: 8] <= cell_wdata[8*b +: 8];
    if (cell_enable && cell_renable) cell_rdata <= mem[cell_index[5:0]];
  end

  // Four-requester instance, used only for wrap/skip ordering
  logic [3:0]   req4, wen4, lock4, grant4, rvalid4;
  logic [55:0]  idx4;
  logic [15:0]  wbyte4;
  logic [127:0] wdata4;
  logic [31:0]  rdata4, cell_wdata4;
  logic [31:0]  cell_rdata4 = 32'h0;
  logic [13:0]  cell_index4;
  logic [3:0]   cell_wbyte4;
  logic         cell_enable4, cell_wenable4, cell_renable4;

  qgemm_sram_cell_arbiter #(.NUM_REQ(4), .MAX_LOCK(4)) dut4 (
    .clk(clk), .rst(rst),
    .rq_req_list(req4), .rq_wenable_list(wen4), .rq_index_list(idx4),
    .rq_wbyte_list(wbyte4), .rq_wdata_list(wdata4), .rq_lock_list(lock4),
    .rq_grant_list(grant4), .rq_rvalid_list(rvalid4), .rq_rdata(rdata4),
    .cell_index(cell_index4), .cell_enable(cell_enable4), .cell_wenable(cell_wenable4),
    .cell_wenable_byte(cell_wbyte4), .cell_wdata(cell_wdata4),
    .cell_renable(cell_renable4), .cell_rdata(cell_rdata4)
  );

  task automatic applyStimulus(input int n, input logic r, input logic w, input logic [13:0] ix,
                               input logic [3:0] wb, input logic [31:0] d, input logic lk);
    req[n]           = r;
    wen[n]           = w;
    idx[n*14 +: 14]  = ix;
    wbyte[n*4 +: 4]  = wb;
    wdata[n*32 +: 32] = d;
    lock[n]          = lk;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] lock_exp [5];

  initial begin
`ifdef QGEMM_SRAM_ARB_BURST_LOCK_EN
    lock_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
`else
    lock_exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
`endif
    rst = 1'b1;
    req = '0; wen = '0; idx = '0; wbyte = '0; wdata = '0; lock = '0;
    req4 = '0; wen4 = '0; idx4 = '0; wbyte4 = '0; wdata4 = '0; lock4 = '0;
    tick();
    applyStimulus(0, 1'b1, 1'b0, 14'd1, 4'h0, 32'h0, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 14'd2, 4'h0, 32'h0, 1'b0);
    tick();
    checkOutput("reset_grant", grant, 2'b00);
    checkOutput("reset_cell_enable", cell_enable, 1'b0);
    checkOutput("reset_rvalid", rvalid, 2'b00);

    req = '0;
    rst = 1'b0;
    #1;
    checkOutput("idle_grant", grant, 2'b00);
    checkOutput("idle_cell_enable", cell_enable, 1'b0);

    applyStimulus(0, 1'b1, 1'b1, 14'd5, 4'hF, 32'hDEADBEEF, 1'b0);
    #1;
    checkOutput("wr5_grant", grant, 2'b01);
    checkOutput("wr5_cell_wenable", cell_wenable, 1'b1);
    checkOutput("wr5_cell_index", cell_index, 14'd5);
    tick();
    checkOutput("wr5_no_rvalid", rvalid, 2'b00);

    applyStimulus(0, 1'b1, 1'b0, 14'd5, 4'h0, 32'h0, 1'b0);
    #1;
    checkOutput("rd5_grant", grant, 2'b01);
    checkOutput("rd5_cell_renable", cell_renable, 1'b1);
    tick();
    checkOutput("rd5_rvalid", rvalid, 2'b01);
    checkOutput("rd5_rdata", rdata, 32'hDEADBEEF);

    applyStimulus(0, 1'b0, 1'b0, 14'd0, 4'h0, 32'h0, 1'b0);
    applyStimulus(1, 1'b1, 1'b1, 14'd9, 4'hF, 32'h11223344, 1'b0);
    #1;
    checkOutput("wr9_grant", grant, 2'b10);
    tick();
    applyStimulus(1, 1'b1, 1'b1, 14'd9, 4'b0101, 32'hAABBCCDD, 1'b0);
    #1;
    checkOutput("wr9_byte_wbyte", cell_wbyte, 4'b0101);
    tick();
    applyStimulus(1, 1'b1, 1'b0, 14'd9, 4'h0, 32'h0, 1'b0);
    #1;
    checkOutput("rd9_grant", grant, 2'b10);
    tick();
    checkOutput("rd9_rvalid", rvalid, 2'b10);
    checkOutput("rd9_rdata", rdata, 32'h11BB33DD);

    // Both requesters read every cycle: grants alternate and each return is tagged
    applyStimulus(0, 1'b1, 1'b0, 14'd5, 4'h0, 32'h0, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 14'd9, 4'h0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput($sformatf("contend_grant_%0d", i), grant, (i % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      checkOutput($sformatf("contend_rvalid_%0d", i), rvalid, (i % 2 == 0) ? 2'b01 : 2'b10);
      checkOutput($sformatf("contend_rdata_%0d", i), rdata,
                  (i % 2 == 0) ? 32'hDEADBEEF : 32'h11BB33DD);
    end

    applyStimulus(1, 1'b0, 1'b0, 14'd0, 4'h0, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 1'b1, 14'd5, 4'h0, 32'h0, 1'b0);
    #1;
    checkOutput("zero_wbyte_grant", grant, 2'b01);
    checkOutput("zero_wbyte_enable", cell_enable, 1'b1);
    tick();
    applyStimulus(0, 1'b1, 1'b0, 14'd5, 4'h0, 32'h0, 1'b0);
    tick();
    checkOutput("zero_wbyte_rdata", rdata, 32'hDEADBEEF);

    applyStimulus(0, 1'b0, 1'b0, 14'd0, 4'h0, 32'h0, 1'b0);
    applyStimulus(1, 1'b1, 1'b1, 14'd9, 4'hF, 32'h12345678, 1'b0);
    tick();
    applyStimulus(1, 1'b1, 1'b0, 14'd9, 4'h0, 32'h0, 1'b0);
    tick();
    checkOutput("wr_then_rd_rvalid", rvalid, 2'b10);
    checkOutput("wr_then_rd_rdata", rdata, 32'h12345678);

    applyStimulus(0, 1'b1, 1'b0, 14'd5, 4'h0, 32'h0, 1'b1);
    applyStimulus(1, 1'b1, 1'b0, 14'd9, 4'h0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput($sformatf("lock_grant_%0d", i), grant, lock_exp[i]);
      tick();
    end

    // Reset while a read return is pending: the return is dropped at once
    applyStimulus(0, 1'b1, 1'b0, 14'd5, 4'h0, 32'h0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 14'd0, 4'h0, 32'h0, 1'b0);
    #1;
    checkOutput("prereset_grant", grant, 2'b01);
    tick();
    checkOutput("prereset_rvalid", rvalid, 2'b01);
    req = 2'b11;
    rst = 1'b1;
    #1;
    checkOutput("midreset_rvalid", rvalid, 2'b00);
    checkOutput("midreset_grant", grant, 2'b00);
    checkOutput("midreset_cell_enable", cell_enable, 1'b0);
    tick();
    tick();
    checkOutput("inreset_rvalid", rvalid, 2'b00);
    rst = 1'b0;
    #1;
    checkOutput("postreset_grant", grant, 2'b01);
    tick();
    checkOutput("postreset_rvalid", rvalid, 2'b01);
    req = '0;
    tick();

    req4 = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput($sformatf("wrap4_grant_%0d", i), grant4, (i % 2 == 0) ? 4'b0010 : 4'b1000);
      tick();
      checkOutput($sformatf("wrap4_rvalid_%0d", i), rvalid4, (i % 2 == 0) ? 4'b0010 : 4'b1000);
    end
    req4 = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
